// File: rtl/md_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package md_pkg;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic is_iterative(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on {acc, qm}.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] qm_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] qm_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply consumes the multiplier LSB-first and shifts the product in from the top;
    // divide shifts the dividend MSB-first into the partial remainder.
    always_comb begin
        sum    = {1'b0, acc_i} + (qm_i[0] ? {1'b0, operand_i} : '0);
        rem_sh = {acc_i, qm_i[WIDTH-1]};
        diff   = rem_sh[WIDTH-1:0] - operand_i;
        ge     = (rem_sh >= {1'b0, operand_i});
        if (is_div) begin
            acc_o = ge ? diff : rem_sh[WIDTH-1:0];
            qm_o  = {qm_i[WIDTH-2:0], ge};
        end else begin
            acc_o = sum[WIDTH:1];
            qm_o  = {sum[0], qm_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO, stall generation and MFHI/MFLO read port.
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             flush_i,
    input  logic [3:0]       md_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] md_rdata_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    md_op_e           op;
    logic             req, accept, signed_op;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, qm_q, opnd_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_nx, qm_nx;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             is_div_q, neg_q, rem_neg_q, div0_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign op        = md_op_e'(md_op_i);
    assign req       = ex_valid_i & ~flush_i & (op != MD_NONE);
    assign accept    = req & (state_q == IDLE);
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_abs     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div_q),
        .acc_i     (acc_q),
        .qm_i      (qm_q),
        .operand_i (opnd_q),
        .acc_o     (acc_nx),
        .qm_o      (qm_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_iterative(op)) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q != IDLE);
        stall_o = req & busy_o;
        case (op)
            MD_MFHI: md_rdata_o = hi_q;
            MD_MFLO: md_rdata_o = lo_q;
            default: md_rdata_o = '0;
        endcase
    end

    // A division by zero leaves the remainder equal to |a|, so restoring its sign reproduces a_i.
    always_comb begin
        prod_fix = neg_q ? -{acc_q, qm_q} : {acc_q, qm_q};
        quot_fix = div0_q ? DIV0_QUOT : (neg_q ? -qm_q : qm_q);
        rem_fix  = rem_neg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            qm_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_iterative(op)) begin
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        qm_q      <= a_abs;
                        opnd_q    <= b_abs;
                        is_div_q  <= (op == MD_DIV) || (op == MD_DIVU);
                        neg_q     <= signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rem_neg_q <= signed_op & a_i[WIDTH-1];
                        div0_q    <= (b_i == '0);
                    end else if (accept && op == MD_MTHI) begin
                        hi_q <= a_i;
                    end else if (accept && op == MD_MTLO) begin
                        lo_q <= a_i;
                    end
                end
                RUN: begin
                    acc_q <= acc_nx;
                    qm_q  <= qm_nx;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table plus stall, flush and reset sequences.
module tb_ex_muldiv_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  md_op_i = 4'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        stall_o, busy_o;
    logic [31:0] md_rdata_o, hi_o, lo_o;

    int tests = 0;
    int failures = 0;

    typedef struct {
        string       name;
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid_i (ex_valid_i),
        .flush_i    (flush_i),
        .md_op_i    (md_op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .md_rdata_o (md_rdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic valid, input logic flush);
        md_op_i    = op;
        a_i        = a;
        b_i        = b;
        ex_valid_i = valid;
        flush_i    = flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one op for a cycle, then counts busy cycles (bounded) with inputs idle.
    task automatic runOp(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        applyStimulus(op, a, b, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);
        cycles = 0;
        while (busy_o && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{"mult_neg3x7",    MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{"multu_max",      MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{"div_neg7by2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{"div_overflow",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{"divu_by0",       MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[5]  = '{"divu_100by7",    MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{"div_7byneg2",    MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{"mult_minsq",     MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{"div_neg8by0",    MD_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[9]  = '{"multu_shift",    MD_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{"mult_5xneg1",    MD_MULT,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[11] = '{"divu_max_by1",   MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};

        #12;
        checkOutput("reset_hi", hi_o, 32'd0);
        checkOutput("reset_lo", lo_o, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            checkOutput({vecs[i].name, "_latency"}, 32'(cyc), 32'd33);
            applyStimulus(MD_MFHI, '0, '0, 1'b1, 1'b0);
            #1 checkOutput({vecs[i].name, "_mfhi"}, md_rdata_o, vecs[i].hi);
            applyStimulus(MD_MFLO, '0, '0, 1'b1, 1'b0);
            #1 checkOutput({vecs[i].name, "_mflo"}, md_rdata_o, vecs[i].lo);
            checkOutput({vecs[i].name, "_stall_idle"}, {31'd0, stall_o}, 32'd0);
            applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end

        // MFHI right behind a MULT stalls for the whole operation, then reads the new HI.
        applyStimulus(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(MD_MFHI, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        cyc = 0;
        while (stall_o && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("mfhi_stall_cycles", 32'(cyc), 32'd33);
        checkOutput("mfhi_after_stall", md_rdata_o, 32'd3);
        @(posedge clk); #1;
        applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);
        checkOutput("mfhi_no_restart", {31'd0, busy_o}, 32'd0);
        checkOutput("mult_lo_after_mfhi", lo_o, 32'd0);

        // MTHI/MTLO write at the accept edge; a flushed MTLO has no effect.
        applyStimulus(MD_MTHI, 32'hDEAD_BEEF, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(MD_MTLO, 32'h0000_A5A5, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("mthi_write", hi_o, 32'hDEAD_BEEF);
        checkOutput("mtlo_write", lo_o, 32'h0000_A5A5);
        applyStimulus(MD_MTLO, 32'h0000_1234, '0, 1'b1, 1'b1);
        #1 checkOutput("mtlo_flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        checkOutput("mtlo_flush_lo", lo_o, 32'h0000_A5A5);
        applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);

        // A flush while busy neither stalls nor cancels the in-flight divide.
        applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(MD_MULT, 32'd9, 32'd9, 1'b1, 1'b1);
        #1 checkOutput("flush_busy_stall", {31'd0, stall_o}, 32'd0);
        applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);
        cyc = 0;
        while (busy_o && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("flush_busy_lo", lo_o, 32'd14);
        checkOutput("flush_busy_hi", hi_o, 32'd2);

        // Asynchronous reset in the middle of a DIV clears everything at once.
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(MD_NONE, '0, '0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_hi", hi_o, 32'd0);
        checkOutput("midreset_lo", lo_o, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy_o}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        runOp(MD_MULT, 32'd6, 32'd7, cyc);
        checkOutput("postreset_latency", 32'(cyc), 32'd33);
        checkOutput("postreset_hi", hi_o, 32'd0);
        checkOutput("postreset_lo", lo_o, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
